// File: rtl/card_deal_arbiter.sv
// Round-robin arbiter sharing one card LUT between NREQ requesters, with redraw and deal limit.
// Optional DECK_TRACK_EN: per-rank counts cap each rank at four deliveries per round.
module card_deal_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned LUT_LAT   = 1,
  parameter int unsigned MAX_DEAL  = 10,
  parameter int unsigned RETRY_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            new_round,
  output logic            lut_pip,
  input  logic [3:0]      lut_number,
  output logic [NREQ-1:0] done,
  output logic [3:0]      card_out,
  output logic            busy,
  output logic            deck_empty,
  output logic [5:0]      deal_cnt,
  output logic            err
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RW-1:0] RetryLast = RW'(RETRY_MAX);
  localparam logic [5:0]    DealMax   = 6'(MAX_DEAL);
  localparam logic [1:0]    WaitLast  = 2'(LUT_LAT - 2);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StDeliver} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   gnt_q;
  logic [RW-1:0]   retry_q;
  logic [1:0]      wait_q;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [31:0]     search_idx;
  logic            rank_ok;
  logic            redraw;

  // First set request at or after the pointer, wrapping mod NREQ.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    search_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      search_idx = (32'(ptr_q) + i) % NREQ;
      if (!gnt_found && req[IW'(search_idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(search_idx);
      end
    end
  end

  assign rank_ok = (lut_number != 4'd0) && (lut_number <= 4'd13);

`ifdef DECK_TRACK_EN
  logic [2:0] rank_cnt [13];
  logic [3:0] rank_idx;
  logic       rank_full;

  assign rank_idx  = lut_number - 4'd1;
  assign rank_full = rank_ok && (rank_cnt[rank_idx] == 3'd4);
  assign redraw    = !rank_ok || rank_full;
`else
  assign redraw = !rank_ok;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gnt_q      <= '0;
      retry_q    <= '0;
      wait_q     <= '0;
      lut_pip    <= 1'b0;
      done       <= '0;
      card_out   <= '0;
      busy       <= 1'b0;
      deck_empty <= 1'b0;
      deal_cnt   <= '0;
      err        <= 1'b0;
`ifdef DECK_TRACK_EN
      for (int r = 0; r < 13; r++) rank_cnt[r] <= '0;
`endif
    end else begin
      lut_pip <= 1'b0;
      done    <= '0;
      err     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (new_round) begin
            deal_cnt   <= '0;
            deck_empty <= 1'b0;
            ptr_q      <= '0;
`ifdef DECK_TRACK_EN
            for (int r = 0; r < 13; r++) rank_cnt[r] <= '0;
`endif
          end else if (gnt_found && !deck_empty) begin
            gnt_q   <= gnt_idx;
            retry_q <= '0;
            lut_pip <= 1'b1;
            busy    <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (LUT_LAT == 1) begin
            state_q <= StCheck;
          end else begin
            wait_q  <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (wait_q == WaitLast) state_q <= StCheck;
          else                    wait_q  <= wait_q + 2'd1;
        end
        StCheck: begin
          if (redraw && (retry_q != RetryLast)) begin
            retry_q <= retry_q + RW'(1);
            lut_pip <= 1'b1;
            state_q <= StIssue;
          end else begin
            done[gnt_q] <= 1'b1;
            card_out    <= lut_number;
            err         <= redraw;
            if (deal_cnt != DealMax) deal_cnt <= deal_cnt + 6'd1;
            deck_empty  <= (deal_cnt == DealMax) || (deal_cnt + 6'd1 == DealMax);
            ptr_q       <= (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
`ifdef DECK_TRACK_EN
            if (rank_ok && (rank_cnt[rank_idx] != 3'd7)) begin
              rank_cnt[rank_idx] <= rank_cnt[rank_idx] + 3'd1;
            end
`endif
            state_q <= StDeliver;
          end
        end
        StDeliver: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_card_deal_arbiter.sv
// Self-checking bench for card_deal_arbiter: vector table, corner sequences, random vs model.
module tb_card_deal_arbiter;
  localparam int NREQ      = 2;
  localparam int LUT_LAT   = 1;
  localparam int MAX_DEAL  = 6;
  localparam int RETRY_MAX = 15;
`ifdef DECK_TRACK_EN
  localparam bit Track = 1'b1;
`else
  localparam bit Track = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            new_round = 1'b0;
  logic            lut_pip;
  logic [3:0]      lut_number = '0;
  logic [NREQ-1:0] done;
  logic [3:0]      card_out;
  logic            busy;
  logic            deck_empty;
  logic [5:0]      deal_cnt;
  logic            err;

  always #5 clk = ~clk;

  card_deal_arbiter #(
    .NREQ(NREQ), .LUT_LAT(LUT_LAT), .MAX_DEAL(MAX_DEAL), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .new_round(new_round), .lut_pip(lut_pip),
    .lut_number(lut_number), .done(done), .card_out(card_out), .busy(busy),
    .deck_empty(deck_empty), .deal_cnt(deal_cnt), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: round-level bookkeeping only.
  int m_ptr, m_deal;
  int m_rank[13];

  function automatic void model_clear();
    m_ptr = 0;
    m_deal = 0;
    for (int r = 0; r < 13; r++) m_rank[r] = 0;
  endfunction

  // LUT stand-in: each pip loads the next scripted rank; exhausted script reads as 0.
  int lut_q[$];
  int lut_idx, pips, cyc;

  function automatic int lut_at(input int a);
    return (a < lut_q.size()) ? lut_q[a] : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (lut_pip) begin
      pips++;
      lut_number = 4'(lut_at(lut_idx));
      lut_idx++;
    end
  endtask

  task automatic txn(input string name, input logic [NREQ-1:0] r, input bit drop,
                     input bit nr_mid, output int g_done, output int g_card,
                     output int g_err, output int g_pips, output int g_deal);
    int g, e_card, e_err, e_pips, v;
    bit bad, seen;
    pips = 0; cyc = 0; lut_idx = 0;
    g_done = 0; g_card = 0; g_err = 0; g_pips = 0; g_deal = 0;
    if (r == '0 || m_deal == MAX_DEAL) begin
      req = r;
      repeat (4) step();
      chk({name, " no pip"}, pips, 0);
      chk({name, " idle busy"}, busy, 0);
      req = '0;
      return;
    end
    g = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (r[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
    e_card = 0; e_err = 0; e_pips = 0;
    for (int a = 0; a <= RETRY_MAX; a++) begin
      v = lut_at(a);
      bad = (v < 1 || v > 13);
      if (!bad && Track) bad = (m_rank[v-1] >= 4);
      if (!bad || a == RETRY_MAX) begin
        e_card = v; e_err = bad; e_pips = a + 1;
        break;
      end
    end
    if (e_card >= 1 && e_card <= 13 && m_rank[e_card-1] < 7) m_rank[e_card-1]++;
    if (m_deal < MAX_DEAL) m_deal++;
    m_ptr = (g + 1) % NREQ;

    req = r;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      step();
      if (cyc == 1) begin
        chk({name, " busy"}, busy, 1);
        if (drop) req = '0;
        if (nr_mid) new_round = 1'b1;
      end else begin
        new_round = 1'b0;
      end
      if (done != '0) seen = 1'b1;
    end
    new_round = 1'b0;
    chk({name, " timeout"}, seen, 1);
    g_done = int'(done); g_card = int'(card_out); g_err = int'(err);
    g_pips = pips; g_deal = int'(deal_cnt);
    chk({name, " done"}, done, 1 << g);
    chk({name, " card"}, card_out, e_card);
    chk({name, " err"}, err, e_err);
    chk({name, " pips"}, pips, e_pips);
    chk({name, " latency"}, cyc, e_pips * (LUT_LAT + 1) + 1);
    chk({name, " deal_cnt"}, deal_cnt, m_deal);
    chk({name, " deck_empty"}, deck_empty, m_deal == MAX_DEAL);
    step();
    req = '0;
    chk({name, " busy after"}, busy, 0);
    chk({name, " done pulse"}, done, 0);
    chk({name, " card hold"}, card_out, e_card);
  endtask

  task automatic do_new_round(input logic [NREQ-1:0] r);
    new_round = 1'b1;
    req = r;
    step();
    new_round = 1'b0;
    req = '0;
    chk("new_round no grant", lut_pip, 0);
    chk("new_round deal_cnt", deal_cnt, 0);
    chk("new_round deck_empty", deck_empty, 0);
    model_clear();
  endtask

  typedef struct {
    bit              nr;
    logic [NREQ-1:0] rq;
    int              nv;
    int              v0, v1, v2;
    int              e_done, e_card, e_err, e_pips, e_deal;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int gd, gc, ge, gp, gl, n;
    logic [NREQ-1:0] rr;
    tbl[0] = '{0, 2'b01, 1,  7,  0,  0, 1,  7, 0, 1, 1};
    tbl[1] = '{0, 2'b11, 3,  0, 15, 12, 2, 12, 0, 3, 2};
    tbl[2] = '{0, 2'b11, 1,  9,  0,  0, 1,  9, 0, 1, 3};
    tbl[3] = '{1, 2'b10, 1, 13,  0,  0, 2, 13, 0, 1, 1};
    tbl[4] = '{0, 2'b11, 1,  1,  0,  0, 1,  1, 0, 1, 2};
    tbl[5] = '{0, 2'b01, 2, 14,  3,  0, 1,  3, 0, 2, 3};
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    chk("reset lut_pip", lut_pip, 0);
    chk("reset done", done, 0);
    chk("reset card_out", card_out, 0);
    chk("reset busy", busy, 0);
    chk("reset deck_empty", deck_empty, 0);
    chk("reset deal_cnt", deal_cnt, 0);
    chk("reset err", err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].nr) do_new_round('0);
      lut_q.delete();
      lut_q.push_back(tbl[i].v0);
      if (tbl[i].nv > 1) lut_q.push_back(tbl[i].v1);
      if (tbl[i].nv > 2) lut_q.push_back(tbl[i].v2);
      txn($sformatf("tbl%0d", i), tbl[i].rq, 1'b0, 1'b0, gd, gc, ge, gp, gl);
      chk($sformatf("tbl%0d vec done", i), gd, tbl[i].e_done);
      chk($sformatf("tbl%0d vec card", i), gc, tbl[i].e_card);
      chk($sformatf("tbl%0d vec err", i), ge, tbl[i].e_err);
      chk($sformatf("tbl%0d vec pips", i), gp, tbl[i].e_pips);
      chk($sformatf("tbl%0d vec deal", i), gl, tbl[i].e_deal);
    end

    // Retry limit: LUT stuck at 0.
    do_new_round('0);
    lut_q.delete();
    txn("retry_max", 2'b01, 1'b0, 1'b0, gd, gc, ge, gp, gl);
    chk("retry_max pips16", gp, 16);
    chk("retry_max err1", ge, 1);
    chk("retry_max card0", gc, 0);

    // Five draws of rank 5, then exhaust the deck.
    do_new_round('0);
    for (int i = 0; i < 4; i++) begin
      lut_q.delete(); lut_q.push_back(5);
      txn("rank5", 2'b01, 1'b0, 1'b0, gd, gc, ge, gp, gl);
    end
    lut_q.delete(); lut_q.push_back(5); lut_q.push_back(6);
    txn("rank5 fifth", 2'b10, 1'b1, 1'b0, gd, gc, ge, gp, gl);
    chk("rank5 fifth card", gc, Track ? 6 : 5);
    lut_q.delete(); lut_q.push_back(8);
    txn("last card", 2'b11, 1'b0, 1'b1, gd, gc, ge, gp, gl);
    chk("deck_empty set", deck_empty, 1);
    txn("empty req", 2'b11, 1'b0, 1'b0, gd, gc, ge, gp, gl);
    do_new_round(2'b11);
    lut_q.delete(); lut_q.push_back(4);
    txn("resume", 2'b10, 1'b0, 1'b0, gd, gc, ge, gp, gl);

    // Reset mid-transaction aborts without done.
    lut_q.delete();
    req = 2'b01;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("abort done", done, 0);
    chk("abort busy", busy, 0);
    chk("abort lut_pip", lut_pip, 0);
    chk("abort deal_cnt", deal_cnt, 0);
    req = '0;
    step();
    rst_n = 1'b1;
    model_clear();
    lut_q.delete(); lut_q.push_back(11);
    txn("post abort", 2'b11, 1'b0, 1'b0, gd, gc, ge, gp, gl);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) do_new_round(NREQ'($urandom_range(0, 3)));
      lut_q.delete();
      if ($urandom_range(0, 9) != 0) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
          if ($urandom_range(0, 9) < 7) lut_q.push_back($urandom_range(1, 13));
          else lut_q.push_back((k % 3 == 0) ? 0 : 13 + $urandom_range(1, 2));
        end
      end
      rr = NREQ'($urandom_range(0, 3));
      txn($sformatf("rnd%0d", t), rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          gd, gc, ge, gp, gl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
